// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles every non-clock signal of the fetch/PC stage: the instruction
//   memory req/ack bus, the held instruction and PC presented to decode, the
//   decoder/ALU inputs used to select the next PC, and the status outputs.
//
//   Modports:
//     master - the fetch unit itself (drives imem_req/addr, instr, pc, ...)
//     slave  - the environment: instruction memory, decoder, ALU, datapath
//
//   Signals:
//     imem_req     fetch request, registered
//     imem_addr    byte address, always equal to pc
//     imem_ack     imem_rdata valid this cycle (only sampled while imem_req)
//     imem_rdata   instruction word from memory
//     instr        held instruction for decode/execute
//     instr_valid  instr is valid and executing
//     pc           address of the current instruction
//     pc_plus4     pc + 4, combinational
//     exec_done    datapath finished the current instruction
//     branch/jump/jumpR  decoder control flags
//     zero         ALU zero flag of the bne compare
//     reg_rs       rs register value, jr target
//     err          sticky misaligned-jr fault
//     retired      count of retired instructions
// ----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done;
    logic        branch;
    logic        jump;
    logic        jumpR;
    logic        zero;
    logic [31:0] reg_rs;
    logic        err;
    logic [31:0] retired;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr,
        output instr_valid,
        output pc,
        output pc_plus4,
        input  exec_done,
        input  branch,
        input  jump,
        input  jumpR,
        input  zero,
        input  reg_rs,
        output err,
        output retired
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr,
        input  instr_valid,
        input  pc,
        input  pc_plus4,
        output exec_done,
        output branch,
        output jump,
        output jumpR,
        output zero,
        output reg_rs,
        input  err,
        input  retired
    );
endinterface

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch and program-counter stage of the MIPS core. Fetches one
//   instruction over a req/ack handshake, holds it stable while the datapath
//   executes it, then commits the next PC when exec_done is seen.
//
//   Next-PC priority on commit: jr (reg_rs) > j (pseudo-direct) >
//   bne taken (pc+4 + sext(imm)<<2) > pc+4. A jr to a non-word-aligned target
//   raises a sticky err and parks the unit in an absorbing ERR state.
//
//   Ports:
//     clk    single clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    fetch_unit_if.master, see the interface for signal list
//
//   Parameter:
//     RESET_PC  word-aligned PC loaded on reset
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        StStart = 2'd0,
        StFetch = 2'd1,
        StExec  = 2'd2,
        StErr   = 2'd3
    } state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_imem_req;
    logic        r_err;
    logic [31:0] r_retired;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_offset;
    logic [31:0] w_br_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_next_pc;
    logic        w_jr_misaligned;

    // ------------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------------
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_br_offset   = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_br_target   = w_pc_plus4 + w_br_offset;
    assign w_jump_target = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};

    // Only meaningful on the exec_done cycle; jumpR gates reg_rs so an X on
    // reg_rs cannot raise a fault for non-jr instructions.
    assign w_jr_misaligned = bus.jumpR && (bus.reg_rs[1:0] != 2'b00);

    // Nested if/else rather than a mux tree so a lower-priority flag is never
    // even evaluated once a higher one is set; the decoder leaves branch as a
    // don't-care on j/jr.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (bus.jumpR) begin
            w_next_pc = bus.reg_rs;
        end else if (bus.jump) begin
            w_next_pc = w_jump_target;
        end else if (bus.branch && !bus.zero) begin
            w_next_pc = w_br_target;
        end else begin
            w_next_pc = w_pc_plus4;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StStart;
            r_pc          <= RESET_PC;
            r_instr       <= 32'h0000_0000;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
            r_err         <= 1'b0;
            r_retired     <= 32'h0000_0000;
        end else begin
            unique case (r_state)
                StStart: begin
                    r_state    <= StFetch;
                    r_imem_req <= 1'b1;
                end

                StFetch: begin
                    // Wait states are unbounded; everything holds until ack.
                    if (bus.imem_ack) begin
                        r_instr       <= bus.imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= StExec;
                    end
                end

                StExec: begin
                    if (bus.exec_done) begin
                        if (w_jr_misaligned) begin
                            // pc and retired stay on the faulting jr.
                            r_err         <= 1'b1;
                            r_instr_valid <= 1'b0;
                            r_state       <= StErr;
                        end else begin
                            r_pc          <= w_next_pc;
                            r_instr_valid <= 1'b0;
                            r_imem_req    <= 1'b1;
                            r_retired     <= r_retired + 32'd1;
                            r_state       <= StFetch;
                        end
                    end
                end

                StErr: begin
                    // Absorbing: only rst_n leaves this state.
                end

                default: begin
                    r_state <= StErr;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.err         = r_err;
    assign bus.retired     = r_retired;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter stage of the MIPS core. It feeds the instruction decoder and consumes that decoder's `branch`/`jump`/`jumpR` flags, the ALU `zero` flag and the `rs` register value to pick the next PC. Each instruction is fetched from instruction memory over a req/ack handshake, then held stable while the rest of the datapath executes it. The next PC is committed when the datapath signals `exec_done`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: fetch request, registered.
- `imem_addr`  out  32: byte address, always equal to `pc`.
- `imem_ack`  in  1: `imem_rdata` is valid this cycle. Sampled only while `imem_req`=1.
- `imem_rdata`  in  32: instruction word.
- `instr`  out  32: held instruction for decode/execute.
- `instr_valid`  out  1: `instr` is valid and executing.
- `pc`  out  32: address of the current instruction.
- `pc_plus4`  out  32: `pc + 4`, modulo 2^32, combinational.
- `exec_done`  in  1: the datapath has finished the current instruction. Sampled only in EXEC.
- `branch`, `jump`, `jumpR`  in  1 each: decoder control flags.
- `zero`  in  1: ALU zero flag from the `bne` compare.
- `reg_rs`  in  32: rs register value, used as the jr target.
- `err`  out  1: sticky misaligned-jr fault.
- `retired`  out  32: count of retired instructions.

## Operation
- Reset (async, `rst_n`=0) drives every output and all state to its reset value:
  - `pc` = RESET_PC.
  - `imem_req`, `instr_valid`, `err` = 0.
  - `instr` = 0 and `retired` = 0.
  - state = START.
- START: unconditionally go to FETCH on the next edge and set `imem_req` = 1.
- FETCH: `imem_req` = 1. On a cycle with `imem_ack` = 1:
  - `instr` <= `imem_rdata` and `instr_valid` <= 1.
  - `imem_req` <= 0 and state <= EXEC.
  - With no ack, hold everything; wait states are unbounded.
- EXEC: `instr` and `pc` are held stable and `imem_ack` is ignored. On a cycle with `exec_done` = 1, the next PC is chosen by strict priority:
  - `jumpR` = 1: `reg_rs`.
  - else `jump` = 1: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - else `branch` = 1 and `zero` = 0 (bne taken): `pc_plus4` + (sign-extended `instr[15:0]` << 2).
  - else: `pc_plus4`.
  - The priority ordering makes the decoder's don't-care `branch` on j/jr irrelevant. An X on a lower-priority flag must never reach `pc`.
- Commit, taken on the `exec_done` cycle:
  - `pc` <= next PC.
  - `instr_valid` <= 0 and `imem_req` <= 1.
  - `retired` <= `retired` + 1 and state <= FETCH.
- Misaligned jr: if `exec_done` = 1 with `jumpR` = 1 and `reg_rs[1:0]` != 0:
  - `err` <= 1, state <= ERR, `instr_valid` <= 0.
  - `pc` and `retired` are unchanged and `imem_req` stays 0.
- ERR: absorbing state with all outputs frozen. Only `rst_n` exits it.
- Arithmetic: all PC adds are 32-bit modulo 2^32 with no overflow detection. `retired` wraps from FFFF_FFFF to 0.

## Timing
- `imem_req` rises one cycle after `rst_n` deasserts (the START cycle).
- `imem_ack` may be asserted in the same cycle `imem_req` first goes high (zero-wait memory). `instr_valid` then rises on the next edge.
- Minimum 2 cycles per instruction: 1 in FETCH plus 1 in EXEC with `exec_done` held high.
- `exec_done` in FETCH or START is ignored. `imem_ack` outside FETCH is ignored.
- `pc` changes only on a commit edge or reset. `imem_addr` is therefore stable for the entire time `imem_req` is high.
- Reset asserted mid-fetch or mid-execute:
  - All state is cleared immediately.
  - An in-flight ack arriving during or after reset is ignored until FETCH is re-entered.

## Test plan
- Reset then sequential execution, RESET_PC = 0, zero-wait memory, `exec_done` = 1, all flags 0:
  - `imem_addr` follows 0, 4, 8, 12 on every second cycle.
  - `retired` reaches 3 after three commits.
- Wait states: ack delayed 3 cycles.
  - `imem_req` stays high for 4 cycles with `imem_addr` stable.
  - `instr_valid` = 0 throughout, then `instr` = `imem_rdata` = 32'h0000_0020.
- Branch and jump:
  - `pc` = 0x40, `instr[15:0]` = 0xFFFE, `branch` = 1, `zero` = 0: next `pc` = 0x3C.
  - Same with `zero` = 1: next `pc` = 0x44.
  - `pc` = 0x40, `jump` = 1, `branch` = X, `instr[25:0]` = 0x10: next `pc` = 0x40.
- jr:
  - `jumpR` = 1, `reg_rs` = 0x100: next `pc` = 0x100.
  - `reg_rs` = 0x102: `err` = 1, `imem_req` stays 0 indefinitely, `pc` unchanged.
- Wrap-around: `pc` = 0xFFFF_FFFC with no flags commits to `pc` = 0.
- Reset mid-wait: `rst_n` pulsed low while `imem_req` = 1.
  - All outputs return to reset values.
  - A stale ack during reset is ignored.
  - Fetch restarts at RESET_PC.
